hls_macc_vec: RTL

Parametrised, key-locked vector multiply-accumulate core with an HLS-style block-level handshake (ap_start/ap_done/ap_idle/ap_ready). It computes a signed dot product of LANES operand pairs and combines it with an accumulator input according to a per-call mode. It is the multi-lane, multi-mode successor of the scalar locked MAC and sits behind the same wrapper style, with the locking key supplied as a port. The result is correct only when the applied key matches the built-in key.

---
 rtl/hls_macc_vec_if.sv | 30 +++
 rtl/hls_macc_vec.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hls_macc_vec_if.sv
// Block-level HLS handshake and operand bus for the key-locked vector MAC.
// The slave modport is the core side; the master modport is the caller side.
interface hls_macc_vec_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int ACC_W  = 64,
  parameter int KEY_W  = 32
) ();
  logic                      ap_start;
  logic                      ap_done;
  logic                      ap_idle;
  logic                      ap_ready;
  logic [1:0]                mode;
  logic [LANES*DATA_W-1:0]   in_a;
  logic [LANES*DATA_W-1:0]   in_b;
  logic [ACC_W-1:0]          acc_i;
  logic [ACC_W-1:0]          acc_o;
  logic                      acc_o_ap_vld;
  logic [KEY_W-1:0]          working_key;

  modport slave (
    input  ap_start, mode, in_a, in_b, acc_i, working_key,
    output ap_done, ap_idle, ap_ready, acc_o, acc_o_ap_vld
  );

  modport master (
    output ap_start, mode, in_a, in_b, acc_i, working_key,
    input  ap_done, ap_idle, ap_ready, acc_o, acc_o_ap_vld
  );
endinterface

// File: rtl/hls_macc_vec.sv
// Key-locked signed vector multiply-accumulate, one lane per cycle, with an
// HLS-style ap_start/ap_done/ap_idle/ap_ready block handshake.
module hls_macc_vec #(
  parameter int               DATA_W    = 32,
  parameter int               LANES     = 4,
  parameter int               ACC_W     = 64,
  parameter int               KEY_W     = 32,
  parameter logic [KEY_W-1:0] KEY_VALUE = 32'hA5C3_0F96
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  hls_macc_vec_if.slave bus
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        laneCnt_q, laneCnt_d;
  logic [ACC_W-1:0]        partialSum_q, partialSum_d;
  logic [LANES*DATA_W-1:0] aOps_q, aOps_d;
  logic [LANES*DATA_W-1:0] bOps_q, bOps_d;
  logic [ACC_W-1:0]        accIn_q, accIn_d;
  logic [1:0]              mode_q, mode_d;
  logic [KEY_W-1:0]        key_q, key_d;
  logic [ACC_W-1:0]        accOut_q, accOut_d;

  logic signed [DATA_W-1:0]   laneA, laneB;
  logic signed [2*DATA_W-1:0] product;
  logic [ACC_W-1:0]           productExt;
  logic [ACC_W-1:0]           sumNext;
  logic [ACC_W-1:0]           rawResult;
  logic [KEY_W-1:0]           keyDiff;
  logic [ACC_W-1:0]           keyMask;

  always_comb begin
    laneA = '0;
    laneB = '0;
    for (int i = 0; i < LANES; i++) begin
      if (laneCnt_q == CNT_W'(i)) begin
        laneA = aOps_q[i*DATA_W +: DATA_W];
        laneB = bOps_q[i*DATA_W +: DATA_W];
      end
    end
  end

  assign product    = laneA * laneB;
  assign productExt = ACC_W'(product);
  assign sumNext    = partialSum_q + productExt;

  // Wrong-key bits are folded onto the result width, so a correct key gives a zero mask.
  always_comb begin
    keyDiff = key_q ^ KEY_VALUE;
    keyMask = '0;
    for (int k = 0; k < KEY_W; k++) begin
      keyMask[k % ACC_W] = keyMask[k % ACC_W] ^ keyDiff[k];
    end
  end

  always_comb begin
    case (mode_q)
      2'd1:    rawResult = accIn_q - sumNext;
      2'd2:    rawResult = sumNext;
      default: rawResult = accIn_q + sumNext;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= IDLE;
      laneCnt_q    <= '0;
      partialSum_q <= '0;
      aOps_q       <= '0;
      bOps_q       <= '0;
      accIn_q      <= '0;
      mode_q       <= '0;
      key_q        <= '0;
      accOut_q     <= '0;
    end else begin
      state_q      <= state_d;
      laneCnt_q    <= laneCnt_d;
      partialSum_q <= partialSum_d;
      aOps_q       <= aOps_d;
      bOps_q       <= bOps_d;
      accIn_q      <= accIn_d;
      mode_q       <= mode_d;
      key_q        <= key_d;
      accOut_q     <= accOut_d;
    end
  end

  // The final combine is taken on the last CALC edge so acc_o is already valid in DONE.
  always_comb begin
    state_d      = state_q;
    laneCnt_d    = laneCnt_q;
    partialSum_d = partialSum_q;
    aOps_d       = aOps_q;
    bOps_d       = bOps_q;
    accIn_d      = accIn_q;
    mode_d       = mode_q;
    key_d        = key_q;
    accOut_d     = accOut_q;
    case (state_q)
      IDLE: begin
        if (bus.ap_start) begin
          aOps_d       = bus.in_a;
          bOps_d       = bus.in_b;
          accIn_d      = bus.acc_i;
          mode_d       = bus.mode;
          key_d        = bus.working_key;
          laneCnt_d    = '0;
          partialSum_d = '0;
          state_d      = CALC;
        end
      end
      CALC: begin
        partialSum_d = sumNext;
        if (laneCnt_q == CNT_W'(LANES - 1)) begin
          accOut_d = rawResult ^ keyMask;
          state_d  = DONE;
        end else begin
          laneCnt_d = laneCnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ap_done      = (state_q == DONE);
  assign bus.ap_ready     = (state_q == DONE);
  assign bus.acc_o_ap_vld = (state_q == DONE);
  assign bus.ap_idle      = (state_q == IDLE) && !bus.ap_start;
  assign bus.acc_o        = accOut_q;

endmodule
